// File: rtl/controlador_cronometros_if.sv
// controlador_cronometros_if: button/datapath side of the clock sequencing controller
interface controlador_cronometros_if;
  logic tick_1hz;
  logic btn_iniciar;
  logic btn_posse;
  logic btn_rebote;
  logic [4:0] posse_segundos;
  logic jogo_zero;
  logic habilita_posse;
  logic habilita_jogo;
  logic carga_posse;
  logic [4:0] carga_posse_valor;
  logic carga_jogo;
  logic buzzer;
  logic [2:0] periodo;
  logic fim_jogo;
  logic [2:0] estado;
  modport master (
    output tick_1hz, btn_iniciar, btn_posse, btn_rebote, posse_segundos, jogo_zero,
    input habilita_posse, habilita_jogo, carga_posse, carga_posse_valor, carga_jogo,
    input buzzer, periodo, fim_jogo, estado
  );
  modport slave (
    input tick_1hz, btn_iniciar, btn_posse, btn_rebote, posse_segundos, jogo_zero,
    output habilita_posse, habilita_jogo, carga_posse, carga_posse_valor, carga_jogo,
    output buzzer, periodo, fim_jogo, estado
  );
endinterface

// File: rtl/controlador_cronometros.sv
// controlador_cronometros: run/stop, reload, expiry, buzzer and period sequencing for shot and game clocks
module controlador_cronometros #(
  parameter logic [4:0] CARGA_LONGA = 5'd24,
  parameter logic [4:0] CARGA_CURTA = 5'd14,
  parameter int BUZZER_TICKS = 3,
  parameter int NUM_PERIODOS = 4
) (
  input logic clock_in,
  input logic reset,
  controlador_cronometros_if.slave bus
);
  localparam int CW = ($clog2(BUZZER_TICKS + 1) < 2) ? 2 : $clog2(BUZZER_TICKS + 1);
  typedef enum logic [2:0] {
    PARADO = 3'd0,
    RODANDO = 3'd1,
    ESTOURO_POSSE = 3'd2,
    FIM_PERIODO = 3'd3,
    FIM_JOGO = 3'd4
  } estado_t;
  estado_t st;
  logic [CW-1:0] ticks;
  logic hab;
  logic carga_posse;
  logic [4:0] carga_valor;
  logic carga_jogo;
  logic buzzer;
  logic [2:0] periodo;
  logic fim_jogo;
  logic ultimo_tick;
  logic ha_periodo;
  assign ultimo_tick = bus.tick_1hz && (ticks == CW'(BUZZER_TICKS - 1));
  assign ha_periodo = periodo < 3'(NUM_PERIODOS);
  // Sequencer: every output is a register updated together with the state
  always_ff @(posedge clock_in) begin
    if (reset) begin
      st <= PARADO;
      ticks <= '0;
      hab <= 1'b0;
      carga_posse <= 1'b0;
      carga_valor <= 5'd0;
      carga_jogo <= 1'b0;
      buzzer <= 1'b0;
      periodo <= 3'd1;
      fim_jogo <= 1'b0;
    end else begin
      carga_posse <= 1'b0;
      carga_valor <= 5'd0;
      carga_jogo <= 1'b0;
      case (st)
        PARADO, RODANDO: begin
          if (st == RODANDO && (bus.jogo_zero || bus.posse_segundos == 5'd0)) begin
            st <= bus.jogo_zero ? FIM_PERIODO : ESTOURO_POSSE;
            hab <= 1'b0;
            buzzer <= 1'b1;
            ticks <= '0;
          end else begin
            if (bus.btn_iniciar) begin
              st <= (st == PARADO) ? RODANDO : PARADO;
              hab <= st == PARADO;
            end
            if (bus.btn_posse) begin
              carga_posse <= 1'b1;
              carga_valor <= CARGA_LONGA;
            end else if (bus.btn_rebote && bus.posse_segundos < CARGA_CURTA) begin
              carga_posse <= 1'b1;
              carga_valor <= CARGA_CURTA;
            end
          end
        end
        ESTOURO_POSSE, FIM_PERIODO: begin
          if (bus.tick_1hz) ticks <= ticks + 1'b1;
          if (ultimo_tick) begin
            buzzer <= 1'b0;
            ticks <= '0;
            if (st == ESTOURO_POSSE || ha_periodo) begin
              st <= PARADO;
              carga_posse <= 1'b1;
              carga_valor <= CARGA_LONGA;
            end else begin
              st <= FIM_JOGO;
              fim_jogo <= 1'b1;
            end
            if (st == FIM_PERIODO && ha_periodo) begin
              periodo <= periodo + 3'd1;
              carga_jogo <= 1'b1;
            end
          end
        end
        default: begin
          st <= FIM_JOGO;
          hab <= 1'b0;
          buzzer <= 1'b0;
          fim_jogo <= 1'b1;
        end
      endcase
    end
  end
  assign bus.habilita_posse = hab;
  assign bus.habilita_jogo = hab;
  assign bus.carga_posse = carga_posse;
  assign bus.carga_posse_valor = carga_valor;
  assign bus.carga_jogo = carga_jogo;
  assign bus.buzzer = buzzer;
  assign bus.periodo = periodo;
  assign bus.fim_jogo = fim_jogo;
  assign bus.estado = st;
endmodule

// File: tb/tb_controlador_cronometros.sv
// tb_controlador_cronometros: directed and random stimulus against a game-level reference model
module tb_controlador_cronometros;
  localparam int LONGA = 24;
  localparam int CURTA = 14;
  localparam int BT = 3;
  localparam int NP = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  controlador_cronometros_if bus ();
  controlador_cronometros dut (.clock_in(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  // Reference model: game phase, remaining buzzer seconds, period, pending strobes
  bit m_run;
  int m_mode;
  int m_left;
  int m_per;
  int e_cp, e_val, e_cj;
  task automatic modelo();
    int ps;
    ps = int'(bus.posse_segundos);
    e_cp = 0;
    e_val = 0;
    e_cj = 0;
    if (rst) begin
      m_run = 0;
      m_mode = 0;
      m_left = 0;
      m_per = 1;
    end else if (m_mode == 0) begin
      if (m_run && (bus.jogo_zero || ps == 0)) begin
        m_mode = bus.jogo_zero ? 2 : 1;
        m_left = BT;
      end else begin
        if (bus.btn_iniciar) m_run = !m_run;
        if (bus.btn_posse) begin
          e_cp = 1;
          e_val = LONGA;
        end else if (bus.btn_rebote && ps < CURTA) begin
          e_cp = 1;
          e_val = CURTA;
        end
      end
    end else if (m_mode != 3) begin
      if (bus.tick_1hz) m_left--;
      if (m_left == 0) begin
        if (m_mode == 2 && m_per == NP) m_mode = 3;
        else begin
          if (m_mode == 2) begin
            m_per++;
            e_cj = 1;
          end
          m_mode = 0;
          m_run = 0;
          e_cp = 1;
          e_val = LONGA;
        end
      end
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all();
    chk("habilita_posse", 8'(bus.habilita_posse), 8'(m_mode == 0 && m_run));
    chk("habilita_jogo", 8'(bus.habilita_jogo), 8'(m_mode == 0 && m_run));
    chk("carga_posse", 8'(bus.carga_posse), 8'(e_cp));
    chk("carga_posse_valor", 8'(bus.carga_posse_valor), 8'(e_val));
    chk("carga_jogo", 8'(bus.carga_jogo), 8'(e_cj));
    chk("buzzer", 8'(bus.buzzer), 8'(m_mode == 1 || m_mode == 2));
    chk("periodo", 8'(bus.periodo), 8'(m_per));
    chk("fim_jogo", 8'(bus.fim_jogo), 8'(m_mode == 3));
    chk("estado", 8'(bus.estado), 8'(m_mode == 0 ? int'(m_run) : m_mode + 1));
  endtask
  task automatic step(input bit ini, input bit bp, input bit br, input bit tk,
                      input bit jz, input bit r, input int ps);
    bus.btn_iniciar = ini;
    bus.btn_posse = bp;
    bus.btn_rebote = br;
    bus.tick_1hz = tk;
    bus.jogo_zero = jz;
    bus.posse_segundos = 5'(ps);
    rst = r;
    @(posedge clk);
    modelo();
    #1;
    chk_all();
  endtask
  task automatic buzina(input int ps);
    for (int i = 0; i < BT; i++) begin
      step(0, 0, 0, 0, 0, 0, ps);
      step(0, 0, 0, 1, 0, 0, ps);
    end
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 1, 10);
    chk("reset_estado", 8'(bus.estado), 8'd0);
    chk("reset_periodo", 8'(bus.periodo), 8'd1);
    step(0, 0, 0, 0, 0, 0, 10);
    step(1, 0, 0, 0, 0, 0, 10);
    chk("start_hab", 8'(bus.habilita_posse), 8'd1);
    step(0, 0, 0, 1, 0, 0, 10);
    step(1, 0, 0, 0, 0, 0, 10);
    chk("stop_hab", 8'(bus.habilita_jogo), 8'd0);
    step(0, 0, 1, 0, 0, 0, 20);
    chk("rebote20_ignorado", 8'(bus.carga_posse), 8'd0);
    step(0, 0, 1, 0, 0, 0, 9);
    chk("rebote9_strobe", 8'(bus.carga_posse), 8'd1);
    chk("rebote9_valor", 8'(bus.carga_posse_valor), 8'd14);
    step(0, 0, 0, 0, 0, 0, 9);
    chk("strobe_um_ciclo", 8'(bus.carga_posse), 8'd0);
    step(0, 1, 1, 0, 0, 0, 9);
    chk("posse_vence_valor", 8'(bus.carga_posse_valor), 8'd24);
    step(0, 0, 1, 0, 0, 0, 14);
    chk("rebote14_ignorado", 8'(bus.carga_posse), 8'd0);
    step(1, 0, 0, 0, 0, 0, 9);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("estouro_estado", 8'(bus.estado), 8'd2);
    chk("estouro_buzzer", 8'(bus.buzzer), 8'd1);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("estouro_ini_ignorado", 8'(bus.estado), 8'd2);
    buzina(0);
    chk("estouro_fim_estado", 8'(bus.estado), 8'd0);
    chk("estouro_fim_valor", 8'(bus.carga_posse_valor), 8'd24);
    step(1, 0, 0, 0, 0, 0, 5);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("simult_estado", 8'(bus.estado), 8'd3);
    buzina(0);
    chk("periodo2", 8'(bus.periodo), 8'd2);
    chk("periodo2_carga_jogo", 8'(bus.carga_jogo), 8'd1);
    for (int p = 2; p <= NP; p++) begin
      step(1, 0, 0, 0, 0, 0, 12);
      step(0, 0, 0, 1, 0, 0, 11);
      step(0, 0, 0, 0, 1, 0, 11);
      buzina(11);
    end
    chk("fim_jogo", 8'(bus.fim_jogo), 8'd1);
    chk("fim_periodo4", 8'(bus.periodo), 8'd4);
    step(1, 1, 1, 1, 1, 0, 3);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("fim_travado", 8'(bus.estado), 8'd4);
    step(0, 0, 0, 0, 0, 1, 10);
    step(1, 0, 0, 0, 0, 0, 10);
    step(0, 0, 0, 0, 1, 0, 10);
    step(0, 0, 0, 1, 0, 0, 10);
    step(0, 0, 0, 1, 0, 1, 10);
    chk("reset_buzina_buzzer", 8'(bus.buzzer), 8'd0);
    chk("reset_buzina_estado", 8'(bus.estado), 8'd0);
    chk("reset_buzina_periodo", 8'(bus.periodo), 8'd1);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, 24)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
